pp_stream_packer: RTL and testbench

- Downstream consumer of the two-bank ping-pong buffer stage.
- Takes the per-bank 4-bit readout nibbles and their bank-active flags.
- Packs four consecutive nibbles into a 16-bit word, tags each word with its source bank and with end-of-frame, and buffers the words in a small FIFO.
- Presents the words on a valid/ready stream to the next consumer. The ping-pong side cannot be stalled, so the FIFO absorbs backpressure and overflow is flagged.

---
 rtl/pp_stream_packer.sv | 241 ++++++++++++++++++++++++
 tb/tb_pp_stream_packer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pp_stream_packer.sv
// ---------------------------------------------------------------------------
// pp_stream_packer
//
// Packs the nibble readout of a two-bank ping-pong buffer into 16-bit words,
// tags each word with its source bank and end-of-frame, and buffers the words
// in a first-word-fall-through FIFO that drives a valid/ready stream. The
// ping-pong side cannot be stalled, so a word arriving at a full FIFO (with no
// pop on the same edge) is dropped and flagged.
//
// Ports
//   clk_100     : system clock, rising edge
//   rst_n       : synchronous active-low reset
//   din_a/vld_a : bank A nibble and its valid
//   din_b/vld_b : bank B nibble and its valid
//   m_data      : packed word, first nibble in [3:0], fourth in [15:12]
//   m_bank      : source bank of m_data (0 = A, 1 = B)
//   m_last      : m_data is the final word of a frame
//   m_valid     : FIFO head valid
//   m_ready     : consumer accepts the head
//   fifo_level  : current FIFO occupancy
//   frame_cnt   : frames completed since reset (wraps)
//   ovf_err     : sticky, a word was dropped on a full FIFO
//   frm_err     : sticky, a frame was truncated or both valids were high
//   clr_err     : synchronous clear of ovf_err and frm_err
// ---------------------------------------------------------------------------
module pp_stream_packer #(
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          clk_100,
  input  logic                          rst_n,
  input  logic [3:0]                    din_a,
  input  logic                          vld_a,
  input  logic [3:0]                    din_b,
  input  logic                          vld_b,
  output logic [15:0]                   m_data,
  output logic                          m_bank,
  output logic                          m_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              frame_cnt,
  output logic                          ovf_err,
  output logic                          frm_err,
  input  logic                          clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(FRAME_LEN);
  localparam logic [SW-1:0] LAST_SMP = SW'(FRAME_LEN - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  // FIFO entry layout: {last, bank, data[15:0]}
  typedef logic [17:0] entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       idx_q,   idx_d;
  logic [15:0]      pack_q,  pack_d;
  logic [SW-1:0]    smp_q,   smp_d;
  logic             bank_q,  bank_d;
  logic [CNT_W-1:0] frame_q, frame_d;

  logic             stg_vld_q,  stg_vld_d;
  entry_t           stg_word_q, stg_word_d;

  entry_t           mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q,  wptr_d;
  logic [AW-1:0]    rptr_q,  rptr_d;
  logic [LW-1:0]    level_q, level_d;
  entry_t           head_q,  head_d;

  logic             ovf_q, ovf_d;
  logic             frm_q, frm_d;

  // ---------------------------------------------------------------------------
  // Input select: bank A wins when both valids are high.
  // ---------------------------------------------------------------------------
  logic       acc;
  logic       both;
  logic [3:0] nib;
  logic       nbank;
  logic       bank_chg;

  assign acc      = vld_a | vld_b;
  assign both     = vld_a & vld_b;
  assign nib      = vld_a ? din_a : din_b;
  assign nbank    = ~vld_a;
  assign bank_chg = acc && (nbank != bank_q) && (smp_q != '0);

  // ---------------------------------------------------------------------------
  // Packer and frame tracking. A completed or flushed word goes to a one-entry
  // staging register and is written to the FIFO on the following edge.
  // ---------------------------------------------------------------------------
  logic [15:0] flush_word;
  logic        frm_evt;

  always_comb begin
    // Lanes at or above the current index are not part of the partial word.
    flush_word = pack_q;
    for (int j = 0; j < 4; j++) begin
      if (2'(j) >= idx_q) flush_word[j*4 +: 4] = 4'h0;
    end
  end

  always_comb begin
    idx_d      = idx_q;
    pack_d     = pack_q;
    smp_d      = smp_q;
    bank_d     = bank_q;
    frame_d    = frame_q;
    stg_vld_d  = 1'b0;
    stg_word_d = stg_word_q;
    frm_evt    = both;

    if (acc) begin
      bank_d = nbank;
      if (bank_chg) begin
        // Truncated frame: close it under the old bank and restart at lane 0.
        // With no nibbles pending (index 0) there is nothing left to flush.
        frm_evt    = 1'b1;
        stg_vld_d  = (idx_q != 2'd0);
        stg_word_d = {1'b1, bank_q, flush_word};
        pack_d     = {12'h000, nib};
        idx_d      = 2'd1;
        smp_d      = SW'(1);
      end else if (idx_q == 2'd3) begin
        stg_vld_d  = 1'b1;
        stg_word_d = {(smp_q == LAST_SMP), nbank, nib, pack_q[11:0]};
        idx_d      = 2'd0;
        if (smp_q == LAST_SMP) begin
          smp_d   = '0;
          frame_d = frame_q + 1'b1;
        end else begin
          smp_d = smp_q + 1'b1;
        end
      end else begin
        pack_d[{idx_q, 2'b00} +: 4] = nib;
        idx_d = idx_q + 1'b1;
        smp_d = smp_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control. A full FIFO still takes the word if the head leaves on the
  // same edge.
  // ---------------------------------------------------------------------------
  logic pop;
  logic push_ok;
  logic drop;

  assign pop     = (level_q != '0) && m_ready;
  assign push_ok = stg_vld_q && ((level_q != FULL_LVL) || pop);
  assign drop    = stg_vld_q && (level_q == FULL_LVL) && !pop;

  always_comb begin
    wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop     ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Registered head: the next head comes from memory when at least two entries
  // are present, otherwise directly from the word being written this edge.
  // With nothing to show, the head keeps its last value.
  always_comb begin
    head_d = head_q;
    if (level_q == '0) begin
      if (push_ok) head_d = stg_word_q;
    end else if (pop) begin
      if (level_q >= LW'(2))  head_d = mem[rptr_q + 1'b1];
      else if (push_ok)       head_d = stg_word_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky errors: a new event on the same edge as clr_err wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    ovf_d = (clr_err ? 1'b0 : ovf_q) | drop;
    frm_d = (clr_err ? 1'b0 : frm_q) | frm_evt;
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      idx_q     <= '0;
      smp_q     <= '0;
      bank_q    <= 1'b0;
      frame_q   <= '0;
      stg_vld_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      head_q    <= '0;
      ovf_q     <= 1'b0;
      frm_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      smp_q     <= smp_d;
      bank_q    <= bank_d;
      frame_q   <= frame_d;
      stg_vld_q <= stg_vld_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      head_q    <= head_d;
      ovf_q     <= ovf_d;
      frm_q     <= frm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Data registers (qualified by the control state above)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100) begin
    pack_q     <= pack_d;
    stg_word_q <= stg_word_d;
    if (push_ok) mem[wptr_q] <= stg_word_q;
  end

  assign m_data     = head_q[15:0];
  assign m_bank     = head_q[16];
  assign m_last     = head_q[17];
  assign m_valid    = (level_q != '0);
  assign fifo_level = level_q;
  assign frame_cnt  = frame_q;
  assign ovf_err    = ovf_q;
  assign frm_err    = frm_q;

endmodule

// File: tb/tb_pp_stream_packer.sv
module tb_pp_stream_packer;

  logic        clk_100 = 1'b0;
  logic        rst_n;
  logic [3:0]  din_a, din_b;
  logic        vld_a, vld_b;
  logic [15:0] m_data;
  logic        m_bank, m_last, m_valid, m_ready;
  logic [4:0]  fifo_level;
  logic [15:0] frame_cnt;
  logic        ovf_err, frm_err, clr_err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] d;
    logic        b;
    logic        l;
  } wd_t;
  wd_t q[$];

  pp_stream_packer #(.FRAME_LEN(1024), .FIFO_DEPTH(16), .CNT_W(16)) dut (
    .clk_100   (clk_100),
    .rst_n     (rst_n),
    .din_a     (din_a),
    .vld_a     (vld_a),
    .din_b     (din_b),
    .vld_b     (vld_b),
    .m_data    (m_data),
    .m_bank    (m_bank),
    .m_last    (m_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .fifo_level(fifo_level),
    .frame_cnt (frame_cnt),
    .ovf_err   (ovf_err),
    .frm_err   (frm_err),
    .clr_err   (clr_err)
  );

  always #5 clk_100 = ~clk_100;

  // Record every accepted word; pops happen on the next rising edge.
  always @(negedge clk_100) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1)
      q.push_back('{d: m_data, b: m_bank, l: m_last});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vld_a = 1'b0; vld_b = 1'b0; clr_err = 1'b0;
    step(); step();
    rst_n = 1'b1;
    q.delete();
  endtask

  // Word w of a stream whose k-th nibble is k mod 16.
  function automatic logic [15:0] exp_word(input int w);
    logic [15:0] r;
    for (int j = 0; j < 4; j++) r[j*4 +: 4] = 4'((4*w + j) % 16);
    return r;
  endfunction

  initial begin
    int bad_d, bad_b, bad_l, n;

    // ---- Reset held with bank A streaming ----
    rst_n = 1'b0; vld_a = 1'b1; din_a = 4'h7; vld_b = 1'b0; din_b = 4'h0;
    m_ready = 1'b0; clr_err = 1'b0;
    step(); step(); step();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_bank", m_bank, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_frm", frm_err, 0);

    // ---- Packing order right after release ----
    rst_n = 1'b1;
    din_a = 4'h1; step();
    din_a = 4'h2; step();
    din_a = 4'h3; step();
    din_a = 4'h4; step();
    vld_a = 1'b0;
    chk("pack_latency_not_yet", m_valid, 0);
    step();
    chk("pack_valid", m_valid, 1);
    chk("pack_data", m_data, 16'h4321);
    chk("pack_bank", m_bank, 0);
    chk("pack_last", m_last, 0);
    chk("pack_level", fifo_level, 1);
    m_ready = 1'b1;
    step();
    chk("pack_drained_level", fifo_level, 0);
    chk("pack_drained_valid", m_valid, 0);

    // ---- Two full frames, bank A then bank B ----
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      vld_a = (i < 1024);
      vld_b = (i >= 1024);
      din_a = 4'(i % 16);
      din_b = 4'(i % 16);
      step();
    end
    vld_a = 1'b0; vld_b = 1'b0;
    repeat (4) step();
    chk("frame_word_count", q.size(), 512);
    bad_d = 0; bad_b = 0; bad_l = 0;
    n = (q.size() < 512) ? q.size() : 512;
    for (int w = 0; w < n; w++) begin
      if (q[w].d !== exp_word(w)) bad_d++;
      if (q[w].b !== (w >= 256)) bad_b++;
      if (q[w].l !== (w == 255 || w == 511)) bad_l++;
    end
    chk("frame_bad_data", bad_d, 0);
    chk("frame_bad_bank", bad_b, 0);
    chk("frame_bad_last", bad_l, 0);
    chk("frame_cnt_two", frame_cnt, 2);
    chk("frame_frm_err", frm_err, 0);
    chk("frame_ovf_err", ovf_err, 0);
    chk("frame_level_empty", fifo_level, 0);

    // ---- Backpressure and overflow ----
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 68; i++) begin
      vld_a = 1'b1;
      din_a = 4'(i % 16);
      step();
    end
    vld_a = 1'b0;
    step(); step();
    chk("ovf_level_full", fifo_level, 16);
    chk("ovf_flag", ovf_err, 1);
    chk("ovf_head_data", m_data, exp_word(0));
    m_ready = 1'b1;
    repeat (20) step();
    chk("ovf_drain_count", q.size(), 16);
    bad_d = 0;
    n = (q.size() < 16) ? q.size() : 16;
    for (int w = 0; w < n; w++) if (q[w].d !== exp_word(w)) bad_d++;
    chk("ovf_drain_order", bad_d, 0);
    chk("ovf_level_empty", fifo_level, 0);
    chk("ovf_still_sticky", ovf_err, 1);
    clr_err = 1'b1; step();
    clr_err = 1'b0;
    chk("ovf_cleared", ovf_err, 0);

    // ---- Truncated frame by bank change ----
    do_reset();
    m_ready = 1'b0;
    vld_a = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      din_a = 4'(i);
      step();
    end
    vld_a = 1'b0; vld_b = 1'b1; din_b = 4'hA; step();
    vld_b = 1'b0; step(); step();
    chk("trunc_level", fifo_level, 2);
    chk("trunc_frm_err", frm_err, 1);
    chk("trunc_frame_cnt", frame_cnt, 0);
    vld_b = 1'b1;
    din_b = 4'hB; step();
    din_b = 4'hC; step();
    din_b = 4'hD; step();
    vld_b = 1'b0; step(); step();
    chk("trunc_level_after_b", fifo_level, 3);
    m_ready = 1'b1;
    repeat (5) step();
    chk("trunc_word_count", q.size(), 3);
    if (q.size() >= 3) begin
      chk("trunc_w0_data", q[0].d, 16'h4321);
      chk("trunc_w0_bank", q[0].b, 0);
      chk("trunc_w0_last", q[0].l, 0);
      chk("trunc_w1_data", q[1].d, 16'h0065);
      chk("trunc_w1_bank", q[1].b, 0);
      chk("trunc_w1_last", q[1].l, 1);
      chk("trunc_w2_data", q[2].d, 16'hDCBA);
      chk("trunc_w2_bank", q[2].b, 1);
      chk("trunc_w2_last", q[2].l, 0);
    end

    // ---- Both valids high ----
    do_reset();
    m_ready = 1'b0;
    vld_a = 1'b1; vld_b = 1'b1; din_a = 4'h5; din_b = 4'h9;
    repeat (4) step();
    vld_a = 1'b0; vld_b = 1'b0;
    step();
    chk("both_valid", m_valid, 1);
    chk("both_data", m_data, 16'h5555);
    chk("both_bank", m_bank, 0);
    chk("both_last", m_last, 0);
    chk("both_frm_err", frm_err, 1);

    // Clear coinciding with a new error leaves the flag set.
    clr_err = 1'b1; vld_a = 1'b1; vld_b = 1'b1; step();
    vld_a = 1'b0; vld_b = 1'b0;
    chk("clr_vs_event", frm_err, 1);
    step();
    clr_err = 1'b0;
    chk("clr_frm", frm_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
